// File: rtl/lcd8080_bus_ctrl.sv
// 8080-bus front end for the i8080-to-RGB bridge: synchronises the host strobes, decodes
// command writes, packs pixels into the line FIFO and provides a colour-bar test generator.
// Optional OVF_COUNT_EN adds a saturating dropped-pixel counter on Ovf_Count.
module lcd8080_bus_ctrl #(
    parameter int BUS_W       = 8,
    parameter int PIX_W       = 16,
    parameter int H_ACTIVE    = 800,
    parameter int BAR_W       = 200,
    parameter int SYNC_STAGES = 2
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             J80_WR,
    input  logic             J80_RS,
    input  logic [BUS_W-1:0] J80_Data,
    input  logic             HSYNC,
    input  logic             VSYNC,
    input  logic             FIFO_Full,
    output logic             FIFO_We,
    output logic [PIX_W-1:0] FIFO_Data,
    output logic             J80_Re,
    output logic             J80_Busy,
    output logic             LCD_BL,
    output logic             FrameCtrl,
    output logic             DisplayOn,
    output logic             Overflow
`ifdef OVF_COUNT_EN
    ,
    output logic [7:0]       Ovf_Count
`endif
);

    localparam int CW  = $clog2(H_ACTIVE + 1);
    localparam int BPW = $clog2(BAR_W + 1);

    typedef enum logic [1:0] {
        GEN_IDLE,
        GEN_RUN,
        GEN_DONE
    } gen_state_t;

    // Host strobe synchronisers: WR, RS and data travel through identical stage counts
    logic [SYNC_STAGES-1:0]            wr_sync;
    logic [SYNC_STAGES-1:0]            rs_sync;
    logic [SYNC_STAGES-1:0][BUS_W-1:0] data_sync;
    logic                              wr_d;
    logic                              evt;
    logic                              evt_rs;
    logic [BUS_W-1:0]                  evt_data;
    logic                              vs_d;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wr_sync   <= '0;
            rs_sync   <= '0;
            data_sync <= '0;
            wr_d      <= 1'b0;
            evt       <= 1'b0;
            evt_rs    <= 1'b0;
            evt_data  <= '0;
            vs_d      <= 1'b0;
        end else begin
            wr_sync   <= {wr_sync[SYNC_STAGES-2:0], J80_WR};
            rs_sync   <= {rs_sync[SYNC_STAGES-2:0], J80_RS};
            data_sync <= {data_sync[SYNC_STAGES-2:0], J80_Data};
            wr_d      <= wr_sync[SYNC_STAGES-1];
            evt       <= wr_sync[SYNC_STAGES-1] & ~wr_d;
            evt_rs    <= rs_sync[SYNC_STAGES-1];
            evt_data  <= data_sync[SYNC_STAGES-1];
            vs_d      <= VSYNC;
        end
    end

    logic       vs_rise;
    logic [2:0] cmd_addr;
    logic [4:0] cmd_pay;
    logic       cmd_wr;
    logic       pix_wr;
    logic       test_en;
    logic       ovf_clr;

    logic [4:0] ctrl_reg;
    logic [4:0] pix_reg;
    logic [4:0] bl_reg;
    logic [4:0] test_reg;

    assign vs_rise  = VSYNC & ~vs_d;
    assign cmd_addr = evt_data[7:5];
    assign cmd_pay  = evt_data[4:0];
    assign test_en  = test_reg[0];
    assign cmd_wr   = evt & evt_rs;
    assign pix_wr   = evt & ~evt_rs & ~test_en;
    assign ovf_clr  = cmd_wr && (cmd_addr == 3'b100) && cmd_pay[1];

    // Pixel assembly; a VSYNC rise in the event cycle realigns before the byte lands
    logic             phase;
    logic             phase_eff;
    logic [7:0]       hi_byte;
    logic [PIX_W-1:0] pix_word;
    logic             pix_done;
    logic             drop;

    assign phase_eff = vs_rise ? 1'b0 : phase;

    always_comb begin
        pix_word = '0;
        pix_done = 1'b0;
        if (BUS_W == 16) begin
            pix_word = PIX_W'(evt_data);
            pix_done = 1'b1;
        end else begin
            pix_word = PIX_W'({hi_byte, evt_data[7:0]});
            pix_done = phase_eff;
        end
    end

    assign drop = pix_wr & pix_done & FIFO_Full;

    // Colour-bar generator
    gen_state_t       state, state_nxt;
    logic [CW-1:0]    count;
    logic [BPW-1:0]   bar_pos;
    logic [1:0]       bar_idx;
    logic             gen_push;
    logic [PIX_W-1:0] bar_color;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= GEN_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        gen_push  = 1'b0;
        if (!test_en || HSYNC || VSYNC) begin
            state_nxt = GEN_IDLE;
        end else begin
            case (state)
                GEN_IDLE: state_nxt = GEN_RUN;
                GEN_RUN: begin
                    if (count == CW'(H_ACTIVE)) state_nxt = GEN_DONE;
                    else                        gen_push  = ~FIFO_Full;
                end
                GEN_DONE: state_nxt = GEN_DONE;
                default:  state_nxt = GEN_IDLE;
            endcase
        end
    end

    always_comb begin
        bar_color = '0;
        case (bar_idx)
            2'd0: bar_color = PIX_W'(16'h0000);
            2'd1: bar_color = PIX_W'(16'hF800);
            2'd2: bar_color = PIX_W'(16'h07E0);
            default: bar_color = PIX_W'(16'h001F);
        endcase
    end

    // Bar index tracked incrementally to avoid a divider on count
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            count   <= '0;
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (state_nxt == GEN_IDLE) begin
            count   <= '0;
            bar_pos <= '0;
            bar_idx <= '0;
        end else if (gen_push) begin
            count <= count + 1'b1;
            if (bar_pos == BPW'(BAR_W - 1)) begin
                bar_pos <= '0;
                bar_idx <= bar_idx + 1'b1;
            end else begin
                bar_pos <= bar_pos + 1'b1;
            end
        end
    end

    // Command registers, byte phase, FIFO push and status
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ctrl_reg  <= 5'b01000;
            pix_reg   <= 5'b00000;
            bl_reg    <= 5'b00001;
            test_reg  <= 5'b00000;
            phase     <= 1'b0;
            hi_byte   <= '0;
            FIFO_We   <= 1'b0;
            FIFO_Data <= '0;
            Overflow  <= 1'b0;
            J80_Busy  <= 1'b0;
            J80_Re    <= 1'b0;
            FrameCtrl <= 1'b1;
        end else begin
            FIFO_We  <= 1'b0;
            J80_Busy <= FIFO_Full;
            J80_Re   <= ctrl_reg[3] ? (HSYNC | VSYNC) : HSYNC;
            FrameCtrl <= ctrl_reg[3] ? 1'b1 : pix_reg[0];

            if (cmd_wr) begin
                phase <= 1'b0;
                case (cmd_addr)
                    3'b001:  ctrl_reg <= cmd_pay;
                    3'b010:  pix_reg  <= cmd_pay;
                    3'b011:  bl_reg   <= cmd_pay;
                    3'b100:  test_reg <= cmd_pay & 5'b11101;
                    default: ;
                endcase
            end else if (pix_wr) begin
                if (BUS_W == 16) phase <= 1'b0;
                else             phase <= ~phase_eff;
                if (!phase_eff) hi_byte <= evt_data[7:0];
            end else if (vs_rise) begin
                phase <= 1'b0;
            end

            if (test_en) begin
                if (gen_push) begin
                    FIFO_We   <= 1'b1;
                    FIFO_Data <= bar_color;
                end
            end else if (pix_wr && pix_done && !FIFO_Full) begin
                FIFO_We   <= 1'b1;
                FIFO_Data <= pix_word;
            end

            if (ovf_clr)   Overflow <= 1'b0;
            else if (drop) Overflow <= 1'b1;
        end
    end

`ifdef OVF_COUNT_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)                          Ovf_Count <= '0;
        else if (ovf_clr)                   Ovf_Count <= '0;
        else if (drop && Ovf_Count != 8'hFF) Ovf_Count <= Ovf_Count + 8'd1;
    end
`endif

    assign DisplayOn = ctrl_reg[4];
    assign LCD_BL    = bl_reg[0];

    logic unused_bits;
    assign unused_bits = ^{ctrl_reg[2:0], pix_reg[4:1], bl_reg[4:1], test_reg[4:1]};

endmodule

// File: tb/tb_lcd8080_bus_ctrl.sv
// Scoreboard bench for lcd8080_bus_ctrl (BUS_W=8): bus writes push expected pixels,
// the FIFO_We monitor pops and compares them.
`timescale 1ns/1ps
module tb_lcd8080_bus_ctrl;

    localparam int BUS_W = 8, PIX_W = 16, H_ACTIVE = 800, BAR_W = 200, SYNC_STAGES = 2;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic             J80_WR = 1'b0;
    logic             J80_RS = 1'b0;
    logic [BUS_W-1:0] J80_Data = '0;
    logic             HSYNC = 1'b0;
    logic             VSYNC = 1'b0;
    logic             FIFO_Full = 1'b0;
    logic             FIFO_We;
    logic [PIX_W-1:0] FIFO_Data;
    logic             J80_Re, J80_Busy, LCD_BL, FrameCtrl, DisplayOn, Overflow;
`ifdef OVF_COUNT_EN
    logic [7:0]       Ovf_Count;
`endif

    lcd8080_bus_ctrl #(
        .BUS_W(BUS_W), .PIX_W(PIX_W), .H_ACTIVE(H_ACTIVE), .BAR_W(BAR_W), .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .CLK(CLK), .nRST(nRST), .J80_WR(J80_WR), .J80_RS(J80_RS), .J80_Data(J80_Data),
        .HSYNC(HSYNC), .VSYNC(VSYNC), .FIFO_Full(FIFO_Full), .FIFO_We(FIFO_We),
        .FIFO_Data(FIFO_Data), .J80_Re(J80_Re), .J80_Busy(J80_Busy), .LCD_BL(LCD_BL),
        .FrameCtrl(FrameCtrl), .DisplayOn(DisplayOn), .Overflow(Overflow)
`ifdef OVF_COUNT_EN
        , .Ovf_Count(Ovf_Count)
`endif
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int last_wr_cyc = 0;
    int pushes = 0;
    bit lat_chk = 1'b0;
    logic [15:0] sb[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard monitor, sampled on the falling edge
    always @(negedge CLK) begin
        if (nRST && FIFO_We) begin
            pushes++;
            if (sb.size() == 0) begin
                chk("unexpected_push", {16'h0, FIFO_Data}, 32'hDEAD_BEEF);
            end else begin
                chk("push_data", FIFO_Data, sb.pop_front());
                if (lat_chk) chk("push_latency", cyc - last_wr_cyc, SYNC_STAGES + 2);
            end
        end
    end

    task automatic bus_write(input logic rs, input logic [7:0] d);
        @(negedge CLK);
        J80_RS = rs; J80_Data = d; J80_WR = 1'b1; last_wr_cyc = cyc;
        repeat (4) @(negedge CLK);
        J80_WR = 1'b0;
        repeat (4) @(negedge CLK);
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", sb.size(), 0);
        sb.delete();
    endtask

    function automatic logic [15:0] bar_col(input int i);
        case ((i / BAR_W) % 4)
            0: return 16'h0000;
            1: return 16'hF800;
            2: return 16'h07E0;
            default: return 16'h001F;
        endcase
    endfunction

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (3) @(negedge CLK);
        nRST = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_bl", LCD_BL, 1);
        chk("rst_framectrl", FrameCtrl, 1);
        chk("rst_displayon", DisplayOn, 0);
        chk("rst_we", FIFO_We, 0);
        chk("rst_data", FIFO_Data, 0);
        chk("rst_ovf", Overflow, 0);
        chk("rst_busy", J80_Busy, 0);
        chk("rst_re", J80_Re, 0);

        // Two-byte pixel, high byte first, with latency check
        sb.push_back(16'hF800);
        lat_chk = 1'b1;
        bus_write(1'b0, 8'hF8);
        bus_write(1'b0, 8'h00);
        wait_drain(20);
        lat_chk = 1'b0;

        // Command registers
        bus_write(1'b1, 8'h30);
        chk("cmd30_displayon", DisplayOn, 1);
        VSYNC = 1'b1;
        repeat (2) @(negedge CLK);
        chk("cmd30_re_manual", J80_Re, 0);
        bus_write(1'b1, 8'h38);
        chk("cmd38_re_auto", J80_Re, 1);
        chk("cmd38_framectrl", FrameCtrl, 1);
        VSYNC = 1'b0;
        bus_write(1'b1, 8'h21);
        chk("cmd21_displayon", DisplayOn, 0);
        chk("cmd21_framectrl", FrameCtrl, 0);
        bus_write(1'b1, 8'h41);
        chk("cmd41_framectrl", FrameCtrl, 1);
        bus_write(1'b1, 8'h60);
        chk("cmd60_bl", LCD_BL, 0);

        // Drop on full FIFO, then clear
        FIFO_Full = 1'b1;
        repeat (2) @(negedge CLK);
        chk("busy_full", J80_Busy, 1);
        bus_write(1'b0, 8'h11);
        bus_write(1'b0, 8'h22);
        chk("ovf_set", Overflow, 1);
        FIFO_Full = 1'b0;
        bus_write(1'b1, 8'h82);
        chk("ovf_clr", Overflow, 0);

        // Command write realigns the byte phase
        bus_write(1'b0, 8'hAA);
        bus_write(1'b1, 8'h30);
        sb.push_back(16'h1234);
        bus_write(1'b0, 8'h12);
        bus_write(1'b0, 8'h34);
        wait_drain(20);

        // VSYNC rise realigns the byte phase
        bus_write(1'b0, 8'h55);
        VSYNC = 1'b1;
        repeat (2) @(negedge CLK);
        VSYNC = 1'b0;
        sb.push_back(16'hABCD);
        bus_write(1'b0, 8'hAB);
        bus_write(1'b0, 8'hCD);
        wait_drain(20);

        // Test mode colour bars with FIFO_Full toggling mid-line
        HSYNC = 1'b1;
        bus_write(1'b1, 8'h81);
        for (int i = 0; i < H_ACTIVE; i++) sb.push_back(bar_col(i));
        base = pushes;
        HSYNC = 1'b0;
        fork
            begin
                int n = 0;
                while ((pushes - base) < H_ACTIVE && n < 4000) begin
                    @(negedge CLK);
                    n++;
                end
            end
            begin
                repeat (5) begin
                    repeat (100) @(negedge CLK);
                    FIFO_Full = 1'b1;
                    repeat (7) @(negedge CLK);
                    FIFO_Full = 1'b0;
                end
            end
        join
        repeat (10) @(negedge CLK);
        chk("gen_pushes", pushes - base, H_ACTIVE);
        chk("gen_no_ovf", Overflow, 0);
        wait_drain(1);

        // Bus pixels discarded in test mode, then exit
        base = pushes;
        bus_write(1'b0, 8'h01);
        bus_write(1'b0, 8'h02);
        repeat (6) @(negedge CLK);
        chk("test_discard", pushes - base, 0);
        bus_write(1'b1, 8'h80);
        sb.push_back(16'h07E0);
        bus_write(1'b0, 8'h07);
        bus_write(1'b0, 8'hE0);
        wait_drain(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
